// File: rtl/display_scheduler_if.sv
// Display scheduler bus: dwell time base, mode availability and user controls in,
// selected display mode and status out.
//   tick         dwell time base, single-cycle pulse
//   mode_valid   per-mode availability (step count, distance, steps/32, active time)
//   hold         level, freezes auto-advance
//   next_req     level, manual advance on its rising edge
//   sel          index of the displayed mode
//   sel_onehot   one-hot decode of sel
//   switch_pulse one-cycle pulse after every change of displayed mode
//   idle         no mode displayable
// The modport master drives the inputs. The modport slave is the scheduler.
interface display_scheduler_if;
    logic       tick;
    logic [3:0] mode_valid;
    logic       hold;
    logic       next_req;
    logic [1:0] sel;
    logic [3:0] sel_onehot;
    logic       switch_pulse;
    logic       idle;

    modport master (
        output tick, mode_valid, hold, next_req,
        input  sel, sel_onehot, switch_pulse, idle
    );

    modport slave (
        input  tick, mode_valid, hold, next_req,
        output sel, sel_onehot, switch_pulse, idle
    );
endinterface

// File: rtl/display_scheduler.sv
// Round-robin display mode scheduler. Each available mode stays on the display
// for DWELL_TICKS tick pulses. The mode also advances on a rising edge of next_req.
// hold freezes the dwell countdown.
// Ports:
//   step_clk  block clock. State updates on its rising edge.
//   reset     asynchronous, active-high
//   bus       display_scheduler_if.slave (tick, mode_valid, hold, next_req in;
//             sel, sel_onehot, switch_pulse, idle out, all registered)
// Configuration:
//   SKIP_INVALID_EN defined   -> the scheduler skips modes that mode_valid marks unavailable.
//                               It idles when no mode is available.
//   SKIP_INVALID_EN undefined -> mode_valid is ignored and the sequence is fixed 0,1,2,3.
module display_scheduler #(
    parameter int unsigned DWELL_TICKS = 4,
    parameter int unsigned CW          = 8
) (
    input  logic               step_clk,
    input  logic               reset,
    display_scheduler_if.slave bus
);
    localparam int unsigned NMODES = 4;
    localparam int unsigned SW     = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_TICKS - 1);

    logic [1:0]        state_q, state_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [NMODES-1:0] onehot_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pulse_q, pulse_d;
    logic              idle_q;
    logic              nreq_q;

    logic [NMODES-1:0] eff_valid;
    logic [SW-1:0]     rr_next;
    logic [SW-1:0]     first_valid;
    logic              nreq_edge;

    // First valid index after base (or from base when inclusive). The scan runs
    // from the farthest offset down, so the nearest valid index is written last.
    function automatic logic [SW-1:0] rr_pick(input logic [SW-1:0] base,
                                              input logic [NMODES-1:0] valid,
                                              input logic inclusive);
        logic [SW-1:0] pick;
        logic [SW-1:0] idx;
        pick = base;
        for (int k = NMODES - 1; k >= 0; k--) begin
            idx = base + SW'(k) + (inclusive ? SW'(0) : SW'(1));
            if (valid[idx]) pick = idx;
        end
        return pick;
    endfunction

`ifdef SKIP_INVALID_EN
    assign eff_valid = bus.mode_valid;
`else
    // Every mode counts as available. The input is folded in only to keep it connected.
    assign eff_valid = bus.mode_valid | 4'b1111;
`endif

    assign rr_next     = rr_pick(sel_q, eff_valid, 1'b0);
    assign first_valid = rr_pick(sel_q, eff_valid, 1'b1);
    assign nreq_edge   = bus.next_req & ~nreq_q;

    // State and output registers
    always_ff @(posedge step_clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            onehot_q <= 4'b0001;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            idle_q   <= 1'b1;
            nreq_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            onehot_q <= 4'b0001 << sel_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            idle_q   <= (state_d == ST_IDLE);
            nreq_q   <= bus.next_req;
        end
    end

    // Next state. The order of the if-chain sets the priority:
    // all-invalid > current-invalid > next_req edge > hold > dwell expiry.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|eff_valid) begin
                    state_d = ST_SHOW;
                    sel_d   = first_valid;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end
            end
            ST_SHOW, ST_HOLD: begin
                state_d = bus.hold ? ST_HOLD : ST_SHOW;
                if (!(|eff_valid)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!eff_valid[sel_q]) begin
                    sel_d   = rr_next;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else if (nreq_edge) begin
                    sel_d   = rr_next;
                    cnt_d   = '0;
                    pulse_d = (rr_next != sel_q);
                end else if (!bus.hold && state_q == ST_SHOW && bus.tick) begin
                    // Ticks count only in SHOW. The cycle that leaves HOLD does not count a tick.
                    if (cnt_q == DWELL_LAST) begin
                        sel_d   = rr_next;
                        cnt_d   = '0;
                        pulse_d = (rr_next != sel_q);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.sel          = sel_q;
    assign bus.sel_onehot   = onehot_q;
    assign bus.switch_pulse = pulse_q;
    assign bus.idle         = idle_q;
endmodule

// File: tb/tb_display_scheduler.sv
// Directed testbench for display_scheduler with DWELL_TICKS=4 and CW=8.
// The bench drives inputs and samples outputs 1 time unit after each rising edge of step_clk.
// The scenarios that use mode_valid to skip modes build only when SKIP_INVALID_EN is defined.
module tb_display_scheduler;
    logic step_clk;
    logic reset;
    int   vectors    = 0;
    int   miscompares = 0;
    int   pulse_cnt  = 0;

    display_scheduler_if bus ();

    display_scheduler #(
        .DWELL_TICKS(4),
        .CW         (8)
    ) dut (
        .step_clk(step_clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial step_clk = 1'b0;
    always #5 step_clk = ~step_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and count any switch_pulse that the edge produced
    task automatic step();
        @(posedge step_clk);
        #1;
        if (bus.switch_pulse) pulse_cnt++;
    endtask

    // n tick pulses, one every 3 cycles
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
            step();
            step();
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.tick       = 1'b0;
        bus.hold       = 1'b0;
        bus.next_req   = 1'b0;
        bus.mode_valid = 4'b1111;

        // Reset state
        step();
        step();
        check("rst_sel", 32'(bus.sel), 0);
        check("rst_onehot", 32'(bus.sel_onehot), 32'h1);
        check("rst_pulse", 32'(bus.switch_pulse), 0);
        check("rst_idle", 32'(bus.idle), 1);

        // First edge after reset leaves IDLE with a switch pulse
        reset = 1'b0;
        step();
        check("start_sel", 32'(bus.sel), 0);
        check("start_pulse", 32'(bus.switch_pulse), 1);
        check("start_idle", 32'(bus.idle), 0);
        step();
        check("start_pulse_drop", 32'(bus.switch_pulse), 0);

        // Full rotation, change only after the 4th tick
        for (int m = 1; m <= 4; m++) begin
            pulse_cnt = 0;
            tick_n(3);
            check("rot_before_sel", 32'(bus.sel), 32'((m - 1) % 4));
            check("rot_before_pulses", 32'(pulse_cnt), 0);
            tick_n(1);
            check("rot_after_sel", 32'(bus.sel), 32'(m % 4));
            check("rot_after_onehot", 32'(bus.sel_onehot), 32'(4'b0001 << (m % 4)));
            check("rot_after_pulses", 32'(pulse_cnt), 1);
        end

        // Hold after 2 ticks: the count is frozen for 10 ticks, then 2 more ticks advance
        pulse_cnt = 0;
        tick_n(2);
        bus.hold = 1'b1;
        step();
        tick_n(10);
        check("hold_sel", 32'(bus.sel), 0);
        check("hold_pulses", 32'(pulse_cnt), 0);
        bus.hold = 1'b0;
        step();
        tick_n(1);
        check("hold_resume1_sel", 32'(bus.sel), 0);
        tick_n(1);
        check("hold_resume2_sel", 32'(bus.sel), 1);
        check("hold_resume_pulses", 32'(pulse_cnt), 1);

        // next_req edge coincides with the final dwell tick, then next_req stays high
        tick_n(3);
        pulse_cnt    = 0;
        bus.tick     = 1'b1;
        bus.next_req = 1'b1;
        step();
        bus.tick = 1'b0;
        check("nreq_sel", 32'(bus.sel), 2);
        check("nreq_pulse", 32'(bus.switch_pulse), 1);
        repeat (19) step();
        check("nreq_level_sel", 32'(bus.sel), 2);
        check("nreq_level_pulses", 32'(pulse_cnt), 1);
        bus.next_req = 1'b0;
        step();
        pulse_cnt = 0;
        tick_n(3);
        check("nreq_cnt_clear_sel", 32'(bus.sel), 2);
        tick_n(1);
        check("nreq_next_sel", 32'(bus.sel), 3);
        check("nreq_next_pulses", 32'(pulse_cnt), 1);

        // Reset mid-dwell with sel=3
        tick_n(2);
        reset = 1'b1;
        #1;
        check("mid_rst_sel", 32'(bus.sel), 0);
        check("mid_rst_onehot", 32'(bus.sel_onehot), 32'h1);
        check("mid_rst_idle", 32'(bus.idle), 1);
        check("mid_rst_pulse", 32'(bus.switch_pulse), 0);
        step();
        check("mid_rst_hold_pulse", 32'(bus.switch_pulse), 0);
        check("mid_rst_hold_sel", 32'(bus.sel), 0);
        reset = 1'b0;
        #1;
        check("post_rst_pulse", 32'(bus.switch_pulse), 0);
        step();
        check("post_rst_idle", 32'(bus.idle), 0);
        pulse_cnt = 0;
        tick_n(3);
        check("post_rst_cnt_sel", 32'(bus.sel), 0);
        tick_n(1);
        check("post_rst_adv_sel", 32'(bus.sel), 1);
        check("post_rst_pulses", 32'(pulse_cnt), 1);

`ifdef SKIP_INVALID_EN
        // Current mode (1) becomes unavailable: advance to 2 on the next edge
        bus.mode_valid = 4'b0101;
        pulse_cnt = 0;
        step();
        check("inval_sel", 32'(bus.sel), 2);
        check("inval_pulses", 32'(pulse_cnt), 1);
        // Expiries alternate between 0 and 2. Modes 1 and 3 are skipped.
        tick_n(4);
        check("skip_sel_a", 32'(bus.sel), 0);
        tick_n(4);
        check("skip_sel_b", 32'(bus.sel), 2);
        tick_n(4);
        check("skip_sel_c", 32'(bus.sel), 0);

        // No mode available: idle with sel retained, then recover to mode 1
        bus.mode_valid = 4'b1111;
        step();
        bus.mode_valid = 4'b0000;
        pulse_cnt = 0;
        step();
        check("allinv_idle", 32'(bus.idle), 1);
        check("allinv_sel", 32'(bus.sel), 0);
        step();
        check("allinv_idle2", 32'(bus.idle), 1);
        check("allinv_pulses", 32'(pulse_cnt), 0);
        bus.mode_valid = 4'b0010;
        step();
        check("recover_sel", 32'(bus.sel), 1);
        check("recover_pulse", 32'(bus.switch_pulse), 1);
        check("recover_idle", 32'(bus.idle), 0);
        step();
        check("recover_pulses", 32'(pulse_cnt), 1);

        // Only the current mode is valid: advance requests keep sel and produce no pulse
        pulse_cnt = 0;
        tick_n(4);
        bus.next_req = 1'b1;
        step();
        bus.next_req = 1'b0;
        step();
        check("single_sel", 32'(bus.sel), 1);
        check("single_onehot", 32'(bus.sel_onehot), 32'h2);
        check("single_pulses", 32'(pulse_cnt), 0);
`else
        // mode_valid is ignored: no idle and the rotation continues
        bus.mode_valid = 4'b0000;
        pulse_cnt = 0;
        step();
        check("novalid_idle", 32'(bus.idle), 0);
        check("novalid_sel", 32'(bus.sel), 1);
        tick_n(4);
        check("novalid_adv_sel", 32'(bus.sel), 2);
        check("novalid_adv_idle", 32'(bus.idle), 0);
        check("novalid_pulses", 32'(pulse_cnt), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter DWELL_TICKS, default 4: number of tick pulses each display mode is shown before auto-advance; legal range 1..255.
REQ-002 Parameter CW, default 8: dwell counter width in bits; DWELL_TICKS SHALL be at most 2^CW-1.
REQ-003 step_clk  in  1  block clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 tick  in  1  dwell time base; single-cycle pulse, already synchronised to step_clk.
REQ-006 mode_valid  in  4  per-mode availability: bit0 step count, bit1 distance, bit2 steps-over-32, bit3 high-activity time.
REQ-007 hold  in  1  level; freezes auto-advance while high.
REQ-008 next_req  in  1  level, synchronous manual-advance request; acted on at its 0->1 transition only.
REQ-009 sel  out  2  registered index of the mode currently driving the display mux.
REQ-010 sel_onehot  out  4  registered one-hot decode of sel.
REQ-011 switch_pulse  out  1  registered; high for exactly one cycle after every change of displayed mode.
REQ-012 idle  out  1  registered; high while no mode is displayable.

Function
REQ-013 FSM states: IDLE (nothing valid), SHOW (counting dwell), HOLD (dwell frozen).
REQ-014 Round-robin search: the next mode is the first valid index in the order sel+1, sel+2, sel+3, sel (mod 4), wrapping 3->0.
REQ-015 IDLE->SHOW on the first edge with mode_valid != 0; sel = first valid index searched from sel inclusive; dwell counter = 0; switch_pulse = 1 on the following cycle.
REQ-016 SHOW: dwell counter increments on each tick; a tick with counter = DWELL_TICKS-1 advances sel per REQ-014, clears the counter and pulses switch_pulse.
REQ-017 A detected next_req rising edge in SHOW or HOLD advances sel immediately, clears the counter and pulses switch_pulse; a simultaneous tick is ignored.
REQ-018 SHOW->HOLD when hold=1; HOLD->SHOW when hold=0; the counter value is preserved across HOLD; ticks are ignored in HOLD.
REQ-019 If mode_valid[sel] drops in SHOW or HOLD while another mode is valid, sel advances on the next edge regardless of hold; counter cleared; switch_pulse asserted.
REQ-020 If mode_valid becomes 0 in SHOW or HOLD: go to IDLE on the next edge; sel retained; counter cleared; idle=1; no switch_pulse.
REQ-021 If the only valid mode is the current one, an advance request (dwell expiry or next_req) leaves sel unchanged, clears the counter and produces no switch_pulse.
REQ-022 Priority per edge: reset > all-invalid > current-invalid > next_req edge > hold > dwell expiry.
REQ-023 Edge detection on next_req uses a registered copy of the previous value; that register resets to 0.
REQ-024 All outputs are registered; sel and sel_onehot change on the same edge that samples the advancing condition.

Reset
REQ-025 On reset assertion, immediately: state=IDLE, sel=0, sel_onehot=4'b0001, dwell counter=0, switch_pulse=0, idle=1, next_req history=0.
REQ-026 Reset asserted mid-dwell or mid-HOLD discards all progress; no switch_pulse is generated by reset.

Configuration
REQ-027 Macro SKIP_INVALID_EN defined: mode_valid behaves as in REQ-014..REQ-021.
REQ-028 SKIP_INVALID_EN undefined: mode_valid is ignored and treated as 4'b1111; sequence is fixed 0->1->2->3->0; IDLE is left on the first edge after reset and is never re-entered; idle=1 only while in reset and until that first edge.

Verification
REQ-029 DWELL_TICKS=4, mode_valid=1111, tick every 3 cycles -> sel sequence 0,1,2,3,0, with each change after the 4th tick; one switch_pulse per change.
REQ-030 mode_valid=0101, sel=0, dwell expiry -> sel=2; next expiry -> sel=0 (modes 1 and 3 skipped).
REQ-031 hold=1 after 2 ticks, 10 ticks in HOLD, then hold=0 -> sel unchanged in HOLD; advance after 2 further ticks.
REQ-032 next_req 0->1 on the same edge as the final dwell tick, sel=1, all valid -> sel=2 exactly once; next_req held high for 20 cycles -> no further advance.
REQ-033 mode_valid drops 1111->0000 in SHOW -> idle=1 next edge, sel held; restored to 0010 -> sel=1, switch_pulse once, idle=0.
REQ-034 reset pulsed mid-dwell with sel=3 -> sel=0, idle=1, counter 0, switch_pulse=0 during and after reset.
